// File: rtl/y_sig_compactor_if.sv
// Bundle of the frame control, beat handshake and result signals of the
// signature compactor. The master side drives frames and beats; the slave
// side is the compactor itself.
interface y_sig_compactor_if #(
  parameter int IN_W  = 350,
  parameter int SIG_W = 32,
  parameter int CNT_W = 16
);
  logic             start;
  logic             mode;
  logic [CNT_W-1:0] frame_len;
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic             drop;
  logic [CNT_W-1:0] beat_cnt;
  logic [SIG_W-1:0] sig;

  modport master (
    output start, mode, frame_len, in_valid, in_data,
    input  in_ready, busy, done, drop, beat_cnt, sig
  );

  modport slave (
    input  start, mode, frame_len, in_valid, in_data,
    output in_ready, busy, done, drop, beat_cnt, sig
  );
endinterface

// File: rtl/y_sig_compactor.sv
// Signature compactor: folds each accepted wide beat down to SIG_W bits and
// accumulates it into a MISR (mode=0) or a plain XOR accumulator (mode=1)
// over a frame of frame_len beats. The final signature stands in for the
// per-cycle output when comparing simulators.
module y_sig_compactor #(
  parameter int               IN_W  = 350,
  parameter int               SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED  = 32'hFFFFFFFF,
  parameter int               CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  y_sig_compactor_if.slave  bus
);

  localparam int K = (IN_W + SIG_W - 1) / SIG_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SIG_W-1:0]   r_sig;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic               r_drop;
  logic               r_mode;
  logic [CNT_W-1:0]   r_len;
  logic               w_ready;
  logic               w_accept;
  logic               w_last;
  logic [SIG_W-1:0]   w_fold;

  // XOR of all SIG_W-bit slices of the zero-extended beat.
  function automatic logic [SIG_W-1:0] fold(input logic [IN_W-1:0] d);
    logic [K*SIG_W-1:0] ext;
    logic [SIG_W-1:0]   acc;
    ext            = '0;
    ext[IN_W-1:0]  = d;
    acc            = '0;
    for (int k = 0; k < K; k++) acc ^= ext[k*SIG_W +: SIG_W];
    return acc;
  endfunction

  // One MISR shift with polynomial feedback from the outgoing MSB.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [SIG_W-1:0] f);
    return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : '0) ^ f;
  endfunction

  assign w_fold   = fold(bus.in_data);
  assign w_ready  = (r_state == RUN);
  assign w_accept = bus.in_valid & w_ready;
  assign w_last   = (r_beat_cnt + CNT_W'(1)) == r_len;

  assign bus.in_ready = w_ready;
  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = (r_state == DONE);
  assign bus.drop     = r_drop;
  assign bus.beat_cnt = r_beat_cnt;
  assign bus.sig      = r_sig;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: start only honoured in IDLE; a zero-length frame skips RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (bus.start) w_state_nxt = (bus.frame_len != '0) ? RUN : DONE;
      RUN:  if (w_accept && w_last) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Frame setup on start, per-beat compaction in RUN, sticky drop otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig      <= SEED;
      r_beat_cnt <= '0;
      r_drop     <= 1'b0;
      r_mode     <= 1'b0;
      r_len      <= '0;
    end else if (r_state == IDLE && bus.start) begin
      r_sig      <= SEED;
      r_beat_cnt <= '0;
      r_drop     <= 1'b0;
      r_mode     <= bus.mode;
      r_len      <= bus.frame_len;
    end else begin
      if (w_accept) begin
        r_sig      <= r_mode ? (r_sig ^ w_fold) : misr_step(r_sig, w_fold);
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
      if (bus.in_valid && !w_ready) r_drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_y_sig_compactor.sv
// Bench for y_sig_compactor: three small instances (8-bit MISR, 12-bit input
// fold, non-zero seed). Expected frame results are queued when a frame is
// issued and checked by per-instance monitors whenever done is high.
module tb_y_sig_compactor;

  logic clk;
  logic rst;

  typedef struct {
    logic [7:0]  sig;
    logic [15:0] cnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t ea, eb, ec;

  int n_chk  = 0;
  int n_pass = 0;

  y_sig_compactor_if #(.IN_W(8),  .SIG_W(8), .CNT_W(16)) ifa ();
  y_sig_compactor_if #(.IN_W(12), .SIG_W(8), .CNT_W(16)) ifb ();
  y_sig_compactor_if #(.IN_W(8),  .SIG_W(8), .CNT_W(16)) ifc ();

  y_sig_compactor #(.IN_W(8),  .SIG_W(8), .POLY(8'h07), .SEED(8'h00), .CNT_W(16))
    u_a (.clk(clk), .rst(rst), .bus(ifa));
  y_sig_compactor #(.IN_W(12), .SIG_W(8), .POLY(8'h07), .SEED(8'h00), .CNT_W(16))
    u_b (.clk(clk), .rst(rst), .bus(ifb));
  y_sig_compactor #(.IN_W(8),  .SIG_W(8), .POLY(8'h07), .SEED(8'hA5), .CNT_W(16))
    u_c (.clk(clk), .rst(rst), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [7:0] s, input logic [15:0] c);
    exp_t e;
    e.sig = s;
    e.cnt = c;
    return e;
  endfunction

  // ---------------- monitors ----------------
  logic pa = 1'b0, pb = 1'b0, pc = 1'b0;

  always @(negedge clk) begin
    if (ifa.done) begin
      chk("a_done_pulse", 32'(pa), 32'd0);
      if (qa.size() == 0) begin
        n_chk++;
        $display("FAIL a_unexpected_done: got done with empty queue, expected none");
      end else begin
        ea = qa.pop_front();
        chk("a_sig", 32'(ifa.sig), 32'(ea.sig));
        chk("a_cnt", 32'(ifa.beat_cnt), 32'(ea.cnt));
      end
    end
    pa = ifa.done;
  end

  always @(negedge clk) begin
    if (ifb.done) begin
      chk("b_done_pulse", 32'(pb), 32'd0);
      if (qb.size() == 0) begin
        n_chk++;
        $display("FAIL b_unexpected_done: got done with empty queue, expected none");
      end else begin
        eb = qb.pop_front();
        chk("b_sig", 32'(ifb.sig), 32'(eb.sig));
        chk("b_cnt", 32'(ifb.beat_cnt), 32'(eb.cnt));
      end
    end
    pb = ifb.done;
  end

  always @(negedge clk) begin
    if (ifc.done) begin
      chk("c_done_pulse", 32'(pc), 32'd0);
      if (qc.size() == 0) begin
        n_chk++;
        $display("FAIL c_unexpected_done: got done with empty queue, expected none");
      end else begin
        ec = qc.pop_front();
        chk("c_sig", 32'(ifc.sig), 32'(ec.sig));
        chk("c_cnt", 32'(ifc.beat_cnt), 32'(ec.cnt));
      end
    end
    pc = ifc.done;
  end

  // ---------------- drivers ----------------
  // Each task leaves the caller at 1 time unit after a rising edge.
  task automatic start_a(input logic m, input logic [15:0] len);
    @(posedge clk); #1;
    ifa.start = 1'b1; ifa.mode = m; ifa.frame_len = len;
    @(posedge clk); #1;
    ifa.start = 1'b0;
  endtask

  task automatic beat_a(input logic [7:0] d);
    ifa.in_valid = 1'b1; ifa.in_data = d;
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
  endtask

  task automatic start_b(input logic m, input logic [15:0] len);
    @(posedge clk); #1;
    ifb.start = 1'b1; ifb.mode = m; ifb.frame_len = len;
    @(posedge clk); #1;
    ifb.start = 1'b0;
  endtask

  task automatic beat_b(input logic [11:0] d);
    ifb.in_valid = 1'b1; ifb.in_data = d;
    @(posedge clk); #1;
    ifb.in_valid = 1'b0;
  endtask

  task automatic start_c(input logic m, input logic [15:0] len);
    @(posedge clk); #1;
    ifc.start = 1'b1; ifc.mode = m; ifc.frame_len = len;
    @(posedge clk); #1;
    ifc.start = 1'b0;
  endtask

  task automatic beat_c(input logic [7:0] d);
    ifc.in_valid = 1'b1; ifc.in_data = d;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    ifa.start = 0; ifa.mode = 0; ifa.frame_len = '0; ifa.in_valid = 0; ifa.in_data = '0;
    ifb.start = 0; ifb.mode = 0; ifb.frame_len = '0; ifb.in_valid = 0; ifb.in_data = '0;
    ifc.start = 0; ifc.mode = 0; ifc.frame_len = '0; ifc.in_valid = 0; ifc.in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_sig",   32'(ifa.sig), 32'h00);
    chk("rst_c_sig",   32'(ifc.sig), 32'hA5);
    chk("rst_a_cnt",   32'(ifa.beat_cnt), 32'd0);
    chk("rst_a_busy",  32'(ifa.busy), 32'd0);
    chk("rst_a_ready", 32'(ifa.in_ready), 32'd0);
    chk("rst_a_done",  32'(ifa.done), 32'd0);
    chk("rst_a_drop",  32'(ifa.drop), 32'd0);
    rst = 1'b0;

    // MISR: 00 -> 01 -> 82 -> (04^07)=03
    qa.push_back(mk(8'h03, 16'd3));
    start_a(1'b0, 16'd3);
    chk("a_ready_after_start", 32'(ifa.in_ready), 32'd1);
    beat_a(8'h01);
    chk("a_sig_beat1", 32'(ifa.sig), 32'h01);
    beat_a(8'h80);
    chk("a_sig_beat2", 32'(ifa.sig), 32'h82);
    beat_a(8'h00);
    chk("a_done_latency", 32'(ifa.done), 32'd1);
    chk("a_ready_in_done", 32'(ifa.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("a_idle_busy", 32'(ifa.busy), 32'd0);
    chk("a_idle_sig_held", 32'(ifa.sig), 32'h03);

    // Drop in IDLE: data discarded, signature untouched
    ifa.in_valid = 1'b1; ifa.in_data = 8'h55;
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    chk("a_drop_set", 32'(ifa.drop), 32'd1);
    chk("a_drop_sig", 32'(ifa.sig), 32'h03);

    // XOR mode, start clears drop, mid-frame start ignored: 12^34=26
    qa.push_back(mk(8'h26, 16'd2));
    start_a(1'b1, 16'd2);
    chk("a_drop_cleared", 32'(ifa.drop), 32'd0);
    beat_a(8'h12);
    ifa.start = 1'b1; ifa.frame_len = 16'd9;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    chk("a_midrun_cnt", 32'(ifa.beat_cnt), 32'd1);
    chk("a_midrun_busy", 32'(ifa.busy), 32'd1);
    beat_a(8'h34);
    chk("a_xor_done", 32'(ifa.done), 32'd1);
    @(posedge clk); #1;

    // Reset mid-frame after 2 of 4 beats
    start_a(1'b0, 16'd4);
    beat_a(8'h01);
    beat_a(8'h80);
    chk("a_partial_sig", 32'(ifa.sig), 32'h82);
    rst = 1'b1;
    #2;
    chk("a_rst_sig",   32'(ifa.sig), 32'h00);
    chk("a_rst_busy",  32'(ifa.busy), 32'd0);
    chk("a_rst_ready", 32'(ifa.in_ready), 32'd0);
    chk("a_rst_cnt",   32'(ifa.beat_cnt), 32'd0);
    rst = 1'b0;
    // Clean frame: 01,82,03, then 03 -> 06^FF = F9
    qa.push_back(mk(8'hF9, 16'd4));
    start_a(1'b0, 16'd4);
    beat_a(8'h01);
    beat_a(8'h80);
    beat_a(8'h00);
    beat_a(8'hFF);
    @(posedge clk); #1;

    // Fold: F0F -> 0F^0F = 00; 123 -> 23^01 = 22
    qb.push_back(mk(8'h00, 16'd1));
    start_b(1'b0, 16'd1);
    beat_b(12'hF0F);
    @(posedge clk); #1;
    qb.push_back(mk(8'h22, 16'd1));
    start_b(1'b0, 16'd1);
    beat_b(12'h123);
    @(posedge clk); #1;

    // Seed A5: one beat 01 -> 4A^07^01 = 4C; then zero-length frame reloads A5
    qc.push_back(mk(8'h4C, 16'd1));
    start_c(1'b0, 16'd1);
    beat_c(8'h01);
    @(posedge clk); #1;
    qc.push_back(mk(8'hA5, 16'd0));
    start_c(1'b0, 16'd0);
    chk("c_zero_len_done", 32'(ifc.done), 32'd1);
    chk("c_zero_len_ready", 32'(ifc.in_ready), 32'd0);

    repeat (4) @(posedge clk);
    #1;
    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);
    chk("c_queue_drained", 32'(qc.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
